// File: rtl/ctrl_pipe.sv
// ============================================================================
//  Module      : ctrl_pipe
//  Description : ID/EX, EX/MEM and MEM/WB control-word pipeline registers,
//                EX-stage redirect (PCSrcE) and retired-instruction counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_pipe #(
    parameter int CNT_W    = 32,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ValidD,
    input  logic                RegWriteD,
    input  logic [1:0]          ResultSrcD,
    input  logic                MemWriteD,
    input  logic                JumpD,
    input  logic                BranchD,
    input  logic                ALUSrcD,
    input  logic [ALUCTL_W-1:0] ALUControlD,
    input  logic [4:0]          RdD,
    input  logic                FlushE,
    input  logic                ZeroE,
    output logic                RegWriteE,
    output logic                MemWriteE,
    output logic                JumpE,
    output logic                BranchE,
    output logic                ALUSrcE,
    output logic [1:0]          ResultSrcE,
    output logic [ALUCTL_W-1:0] ALUControlE,
    output logic [4:0]          RdE,
    output logic                PCSrcE,
    output logic                RegWriteM,
    output logic                MemWriteM,
    output logic [1:0]          ResultSrcM,
    output logic [4:0]          RdM,
    output logic                RegWriteW,
    output logic [1:0]          ResultSrcW,
    output logic [4:0]          RdW,
    output logic [CNT_W-1:0]    Retired
);

    logic r_validE;
    logic r_validM;
    logic r_validW;
    logic w_bubbleE;

    // A flushed or empty ID slot becomes an all-zero bubble in EX.
    assign w_bubbleE = FlushE | ~ValidD;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_validE    <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= '0;
            RdE         <= 5'd0;
        end else if (w_bubbleE) begin
            r_validE    <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= '0;
            RdE         <= 5'd0;
        end else begin
            r_validE    <= 1'b1;
            // Writes to x0 are dropped here so no later stage ever sees them.
            RegWriteE   <= RegWriteD & (RdD != 5'd0);
            MemWriteE   <= MemWriteD;
            JumpE       <= JumpD;
            BranchE     <= BranchD;
            ALUSrcE     <= ALUSrcD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            RdE         <= RdD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_validM   <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            r_validW   <= 1'b0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
        end else begin
            r_validM   <= r_validE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            r_validW   <= r_validM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Retired <= '0;
        end else if (r_validW) begin
            Retired <= Retired + CNT_W'(1);
        end
    end

    assign PCSrcE = (BranchE & ZeroE) | JumpE;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
// ============================================================================
//  Module      : tb_ctrl_pipe
//  Description : Directed self-checking bench for ctrl_pipe (CNT_W = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0] ResultSrcD;
    logic [2:0] ALUControlD;
    logic [4:0] RdD;
    logic       FlushE, ZeroE;
    logic       RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, PCSrcE;
    logic [1:0] ResultSrcE, ResultSrcM, ResultSrcW;
    logic [2:0] ALUControlE;
    logic [4:0] RdE, RdM, RdW;
    logic       RegWriteM, MemWriteM, RegWriteW;
    logic [3:0] Retired;

    int errors = 0;
    int checks = 0;

    ctrl_pipe #(.CNT_W(4), .ALUCTL_W(3)) dut (
        .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RdD(RdD), .FlushE(FlushE), .ZeroE(ZeroE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RdE(RdE), .PCSrcE(PCSrcE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RdM(RdM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .Retired(Retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        ValidD = 0; RegWriteD = 0; ResultSrcD = 2'b00; MemWriteD = 0;
        JumpD = 0; BranchD = 0; ALUSrcD = 0; ALUControlD = 3'd0; RdD = 5'd0;
        FlushE = 0; ZeroE = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        ValidD = 1; RegWriteD = 1; RdD = 5'd3;
        step(2);
        reset = 0;
        idle();
        chk("rst_RegWriteE", RegWriteE, 0);
        chk("rst_RdE", RdE, 0);
        chk("rst_RegWriteM", RegWriteM, 0);
        chk("rst_RegWriteW", RegWriteW, 0);
        chk("rst_Retired", Retired, 0);
        step(1);
        chk("post_rst_RegWriteE", RegWriteE, 0);
        chk("post_rst_PCSrcE", PCSrcE, 0);
        chk("post_rst_Retired", Retired, 0);

        // lw x5
        ValidD = 1; RegWriteD = 1; ResultSrcD = 2'b01; ALUSrcD = 1; RdD = 5'd5; ALUControlD = 3'd2;
        step(1);
        idle();
        chk("lw_RegWriteE", RegWriteE, 1);
        chk("lw_RdE", RdE, 5);
        chk("lw_ALUSrcE", ALUSrcE, 1);
        chk("lw_ResultSrcE", ResultSrcE, 1);
        chk("lw_ALUControlE", ALUControlE, 2);
        step(1);
        chk("lw_RegWriteM", RegWriteM, 1);
        chk("lw_ResultSrcM", ResultSrcM, 1);
        chk("lw_RdM", RdM, 5);
        chk("lw_bubble_RegWriteE", RegWriteE, 0);
        step(1);
        chk("lw_RegWriteW", RegWriteW, 1);
        chk("lw_RdW", RdW, 5);
        chk("lw_ResultSrcW", ResultSrcW, 1);
        chk("lw_Retired_before", Retired, 0);
        step(1);
        chk("lw_Retired", Retired, 1);
        chk("lw_RegWriteW_clear", RegWriteW, 0);

        // beq then jal
        ValidD = 1; BranchD = 1;
        step(1);
        idle();
        ZeroE = 1; #1;
        chk("beq_taken", PCSrcE, 1);
        ZeroE = 0; #1;
        chk("beq_not_taken", PCSrcE, 0);
        ValidD = 1; JumpD = 1;
        step(1);
        idle();
        #1;
        chk("jal_PCSrcE", PCSrcE, 1);
        step(1);
        ZeroE = 1; #1;
        chk("bubble_PCSrcE", PCSrcE, 0);
        ZeroE = 0;
        step(3);
        chk("br_Retired", Retired, 3);

        // older add x7 followed by a flushed sw
        ValidD = 1; RegWriteD = 1; RdD = 5'd7;
        step(1);
        idle();
        ValidD = 1; MemWriteD = 1; FlushE = 1;
        step(1);
        idle();
        chk("flush_MemWriteE", MemWriteE, 0);
        chk("flush_older_RegWriteM", RegWriteM, 1);
        chk("flush_older_RdM", RdM, 7);
        step(1);
        chk("flush_MemWriteM", MemWriteM, 0);
        chk("flush_older_RegWriteW", RegWriteW, 1);
        step(3);
        chk("flush_Retired", Retired, 4);

        // write to x0
        ValidD = 1; RegWriteD = 1; RdD = 5'd0;
        step(1);
        idle();
        chk("x0_RegWriteE", RegWriteE, 0);
        step(1);
        chk("x0_RegWriteM", RegWriteM, 0);
        step(1);
        chk("x0_RegWriteW", RegWriteW, 0);
        step(1);
        chk("x0_Retired", Retired, 5);

        // counter wrap: 17 retirements from zero
        reset = 1;
        step(1);
        reset = 0;
        chk("wrap_start", Retired, 0);
        ValidD = 1; RegWriteD = 1; RdD = 5'd1;
        step(17);
        idle();
        step(3);
        chk("wrap_Retired", Retired, 1);

        // reset with three instructions in flight
        ValidD = 1; RegWriteD = 1; RdD = 5'd9;
        step(3);
        idle();
        chk("inflight_RegWriteW", RegWriteW, 1);
        reset = 1;
        step(1);
        reset = 0;
        chk("midrst_Retired", Retired, 0);
        chk("midrst_RegWriteE", RegWriteE, 0);
        chk("midrst_RegWriteM", RegWriteM, 0);
        chk("midrst_RegWriteW", RegWriteW, 0);
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("midrst_no_wb", RegWriteW, 0);
        end
        chk("midrst_Retired_end", Retired, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
